// File: rtl/cubic_tap_window_if.sv
// Stream bundle between the row feeder, the cubic tap window and the interpolator.
// Latency: none, this is wiring only.
// Backpressure: in_valid/in_ready on the pixel side, out_valid/out_ready on the beat side.
// Ports (signals):
//   in_valid/in_ready/in_data                          pixel stream into the window
//   out_valid/out_ready/a0..a3/out_interp/out_last     window beats to the interpolator
interface cubic_tap_window_if #(
   parameter int bit_depth = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [bit_depth-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [bit_depth-1:0] a0;
   logic [bit_depth-1:0] a1;
   logic [bit_depth-1:0] a2;
   logic [bit_depth-1:0] a3;
   logic                 out_interp;
   logic                 out_last;

   // Producer of pixels / consumer of beats (e.g. the bench or the line buffer).
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, a0, a1, a2, a3, out_interp, out_last
   );

   // The window block itself.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, a0, a1, a2, a3, out_interp, out_last
   );
endinterface

// File: rtl/cubic_tap_window.sv
// 4-tap sliding window with edge replication; emits two beats (original, midpoint) per source pixel.
// Latency: first beat valid the cycle after p2 is accepted; steady state one center per 3 cycles.
// Backpressure: beats hold while out_ready is low; in_ready is low whenever a beat is pending.
// Ports:
//   clk, reset  single rising-edge clock, asynchronous active-high reset
//   bus         slave side of cubic_tap_window_if (pixel input stream, window beat output stream)
module cubic_tap_window #(
   parameter int bit_depth  = 8,
   parameter int line_width = 640
) (
   input logic                clk,
   input logic                reset,
   cubic_tap_window_if.slave  bus
);
   localparam int CW = $clog2(line_width + 1);

   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_TWO  = CW'(2);
   localparam logic [CW-1:0] C_LW   = CW'(line_width);
   localparam logic [CW-1:0] C_LAST = CW'(line_width - 1);

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      EMIT0   = 2'd1,
      EMIT1   = 2'd2,
      WAIT_IN = 2'd3
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_pix_cnt;   // pixels of the current row accepted so far
   logic [CW-1:0]        r_center;    // index i of the window center p[i]
   logic                 r_out_valid;
   logic                 r_out_interp;
   logic                 r_out_last;
   logic [bit_depth-1:0] r_a0;
   logic [bit_depth-1:0] r_a1;
   logic [bit_depth-1:0] r_a2;
   logic [bit_depth-1:0] r_a3;

   logic w_in_ready;
   logic w_in_xfer;
   logic w_out_xfer;

   // Ready is a pure state decode, so it never looks at in_valid; it is
   // forced low while reset is asserted and rises as soon as reset drops.
   assign w_in_ready = ((r_state == FILL) || (r_state == WAIT_IN)) && !reset;
   assign w_in_xfer  = bus.in_valid && w_in_ready;
   assign w_out_xfer = r_out_valid && bus.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= FILL;
         r_pix_cnt    <= '0;
         r_center     <= '0;
         r_out_valid  <= 1'b0;
         r_out_interp <= 1'b0;
         r_out_last   <= 1'b0;
         r_a0         <= '0;
         r_a1         <= '0;
         r_a2         <= '0;
         r_a3         <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_in_xfer) begin
                  r_pix_cnt <= r_pix_cnt + C_ONE;
                  if (r_pix_cnt == C_TWO) begin
                     // p0 and p1 already sit in a2/a3; replicate p0 as the left neighbour.
                     r_a0         <= r_a2;
                     r_a1         <= r_a2;
                     r_a2         <= r_a3;
                     r_a3         <= bus.in_data;
                     r_center     <= '0;
                     r_out_valid  <= 1'b1;
                     r_out_interp <= 1'b0;
                     r_out_last   <= 1'b0;
                     r_state      <= EMIT0;
                  end else begin
                     // Window is not visible yet, so use it as the staging shift register.
                     r_a0 <= r_a1;
                     r_a1 <= r_a2;
                     r_a2 <= r_a3;
                     r_a3 <= bus.in_data;
                  end
               end
            end

            EMIT0: begin
               if (w_out_xfer) begin
                  r_out_interp <= 1'b1;
                  r_out_last   <= (r_center == C_LAST);
                  r_state      <= EMIT1;
               end
            end

            EMIT1: begin
               if (w_out_xfer) begin
                  if (r_pix_cnt < C_LW) begin
                     r_out_valid  <= 1'b0;
                     r_out_interp <= 1'b0;
                     r_out_last   <= 1'b0;
                     r_state      <= WAIT_IN;
                  end else if (r_center < C_LAST) begin
                     // Row fully received: right edge is replicated by leaving a3 in place.
                     r_a0         <= r_a1;
                     r_a1         <= r_a2;
                     r_a2         <= r_a3;
                     r_center     <= r_center + C_ONE;
                     r_out_interp <= 1'b0;
                     r_out_last   <= 1'b0;
                     r_state      <= EMIT0;
                  end else begin
                     r_pix_cnt    <= '0;
                     r_center     <= '0;
                     r_out_valid  <= 1'b0;
                     r_out_interp <= 1'b0;
                     r_out_last   <= 1'b0;
                     r_state      <= FILL;
                  end
               end
            end

            WAIT_IN: begin
               if (w_in_xfer) begin
                  r_a0         <= r_a1;
                  r_a1         <= r_a2;
                  r_a2         <= r_a3;
                  r_a3         <= bus.in_data;
                  r_center     <= r_center + C_ONE;
                  r_pix_cnt    <= r_pix_cnt + C_ONE;
                  r_out_valid  <= 1'b1;
                  r_out_interp <= 1'b0;
                  r_out_last   <= 1'b0;
                  r_state      <= EMIT0;
               end
            end

            default: r_state <= FILL;
         endcase
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_interp = r_out_interp;
   assign bus.out_last   = r_out_last;
   assign bus.a0         = r_a0;
   assign bus.a1         = r_a1;
   assign bus.a2         = r_a2;
   assign bus.a3         = r_a3;
endmodule

// File: tb/tb_cubic_tap_window.sv
// Bench for cubic_tap_window: line_width=4 instance for function/backpressure/reset,
// line_width=8 instance for beat timing. Expected beats come from index clamping of the row.
module tb_cubic_tap_window;
   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   cubic_tap_window_if #(.bit_depth(8)) bus4 ();
   cubic_tap_window_if #(.bit_depth(8)) bus8 ();

   cubic_tap_window #(.bit_depth(8), .line_width(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
   cubic_tap_window #(.bit_depth(8), .line_width(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [7:0]  row_px [0:15];
   logic [63:0] got4[$];
   int          got4_cyc[$];
   logic        got4_ir[$];
   int          acc4_cyc[$];
   logic [63:0] got8[$];
   int          got8_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] pack4();
      return {30'b0, bus4.a0, bus4.a1, bus4.a2, bus4.a3, bus4.out_interp, bus4.out_last};
   endfunction

   function automatic logic [63:0] pack8();
      return {30'b0, bus8.a0, bus8.a1, bus8.a2, bus8.a3, bus8.out_interp, bus8.out_last};
   endfunction

   // Beat k (0 = original, 1 = midpoint) of center c: taps p[c-1..c+2] clamped into the row.
   function automatic logic [63:0] exp_beat(input int lw, input int base, input int c, input int k);
      logic [7:0] s [4];
      for (int j = 0; j < 4; j++) begin
         int idx;
         idx = c - 1 + j;
         if (idx < 0) idx = 0;
         if (idx > lw - 1) idx = lw - 1;
         s[j] = row_px[base + idx];
      end
      return {30'b0, s[0], s[1], s[2], s[3], (k != 0), ((c == lw - 1) && (k != 0))};
   endfunction

   // Sampled away from the clock edge; transfers complete at the following posedge.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus4.out_valid && bus4.out_ready) begin
            got4.push_back(pack4());
            got4_cyc.push_back(cyc);
            got4_ir.push_back(bus4.in_ready);
         end
         if (bus4.in_valid && bus4.in_ready) acc4_cyc.push_back(cyc);
         if (bus8.out_valid && bus8.out_ready) begin
            got8.push_back(pack8());
            got8_cyc.push_back(cyc);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_q();
      got4.delete(); got4_cyc.delete(); got4_ir.delete(); acc4_cyc.delete();
   endtask

   // mode 0: continuous valid, 1: valid toggles every cycle, 2: random valid
   task automatic feed4(input int base, input int n, input int mode);
      int   i = 0;
      int   g = 0;
      logic acc;
      while (i < n && g < 3000) begin
         bus4.in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((g % 2) == 0) : 1'($urandom_range(0, 1));
         bus4.in_data  = row_px[base + i];
         @(negedge clk);
         acc = bus4.in_valid && bus4.in_ready;
         @(posedge clk); #1;
         if (acc) i++;
         g++;
      end
      bus4.in_valid = 1'b0;
      if (i < n) check("feed4_timeout", 64'(i), 64'(n));
   endtask

   // mode 0: ready high, 1: random ready, 2: ready high except a 5-cycle stall on center 1 midpoint
   task automatic collect4(input int nb, input int mode);
      int g       = 0;
      bit stalled = 1'b0;
      while (got4.size() < nb && g < 3000) begin
         if (mode == 2 && !stalled && bus4.out_valid && bus4.out_interp &&
             bus4.a0 == row_px[0] && bus4.a1 == row_px[1]) begin
            bus4.out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               check("stall_window", pack4(), exp_beat(4, 0, 1, 1));
               check("stall_in_ready", 64'(bus4.in_ready), 64'd0);
               check("stall_out_valid", 64'(bus4.out_valid), 64'd1);
               @(posedge clk); #1;
            end
            stalled = 1'b1;
         end
         bus4.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         g++;
      end
      bus4.out_ready = 1'b1;
      if (mode == 2) check("stall_happened", 64'(stalled), 64'd1);
   endtask

   task automatic check_row4(input string tag, input int base, input int off);
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 2; k++) begin
            int idx;
            idx = off + 2 * c + k;
            check(tag, (idx < got4.size()) ? got4[idx] : 64'hx, exp_beat(4, base, c, k));
         end
      end
   endtask

   initial begin
      bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b1;

      // ---- reset state
      #2 reset = 1'b1;
      #2;
      check("rst_window", pack4(), 64'd0);
      check("rst_in_ready", 64'(bus4.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      #1;
      check("rel_in_ready", 64'(bus4.in_ready), 64'd1);
      @(posedge clk); #1;

      // ---- basic row with latency and in_ready during drain
      row_px[0] = 8'd10; row_px[1] = 8'd20; row_px[2] = 8'd30; row_px[3] = 8'd40;
      clear_q();
      fork
         feed4(0, 4, 0);
         collect4(8, 0);
      join
      check("basic_count", 64'(got4.size()), 64'd8);
      check_row4("basic_beat", 0, 0);
      check("latency_p2", 64'(got4_cyc[0]), 64'(acc4_cyc[2] + 1));
      for (int b = 4; b < 8; b++) check("drain_in_ready", 64'(got4_ir[b]), 64'd0);

      // ---- backpressure on center 1 midpoint
      clear_q();
      fork
         feed4(0, 4, 0);
         collect4(8, 2);
      join
      check("bp_count", 64'(got4.size()), 64'd8);
      check_row4("bp_beat", 0, 0);

      // ---- input bubbles
      clear_q();
      fork
         feed4(0, 4, 1);
         collect4(8, 0);
      join
      check("bubble_count", 64'(got4.size()), 64'd8);
      check_row4("bubble_beat", 0, 0);

      // ---- two rows back to back
      for (int i = 0; i < 4; i++) begin
         row_px[i]     = 8'(i + 1);
         row_px[i + 4] = 8'(200 + i);
      end
      clear_q();
      fork
         feed4(0, 8, 0);
         collect4(16, 0);
      join
      check("b2b_count", 64'(got4.size()), 64'd16);
      check_row4("b2b_row1", 0, 0);
      check_row4("b2b_row2", 4, 8);
      check("b2b_first_beat", got4[8], {30'b0, 8'd200, 8'd200, 8'd201, 8'd202, 2'b00});
      check("b2b_fill_start", 64'(acc4_cyc[4]), 64'(got4_cyc[7] + 1));

      // ---- randomized rows with random valid and ready
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) row_px[i] = 8'($urandom);
         clear_q();
         fork
            feed4(0, 4, 2);
            collect4(8, 1);
         join
         check("rand_count", 64'(got4.size()), 64'd8);
         check_row4("rand_beat", 0, 0);
      end

      // ---- reset mid-row after two pixels
      row_px[0] = 8'd90; row_px[1] = 8'd91;
      clear_q();
      feed4(0, 2, 0);
      #2 reset = 1'b1;
      #1;
      check("midrst_window", pack4(), 64'd0);
      check("midrst_in_ready", 64'(bus4.in_ready), 64'd0);
      check("midrst_out_valid", 64'(bus4.out_valid), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      #1;
      check("midrst_rel_ready", 64'(bus4.in_ready), 64'd1);
      @(posedge clk); #1;
      row_px[0] = 8'd5; row_px[1] = 8'd6; row_px[2] = 8'd7; row_px[3] = 8'd8;
      clear_q();
      fork
         feed4(0, 4, 0);
         collect4(8, 0);
      join
      check("midrst_first_beat", got4[0], {30'b0, 8'd5, 8'd5, 8'd6, 8'd7, 2'b00});
      check_row4("midrst_beat", 0, 0);

      // ---- line_width=8 timing with continuous stimulus
      for (int i = 0; i < 8; i++) row_px[i] = 8'($urandom);
      got8.delete(); got8_cyc.delete();
      fork
         begin
            int   i = 0;
            int   g = 0;
            logic acc;
            while (i < 8 && g < 500) begin
               bus8.in_valid = 1'b1;
               bus8.in_data  = row_px[i];
               @(negedge clk);
               acc = bus8.in_valid && bus8.in_ready;
               @(posedge clk); #1;
               if (acc) i++;
               g++;
            end
            bus8.in_valid = 1'b0;
         end
         begin
            int g = 0;
            while (got8.size() < 16 && g < 500) begin
               @(posedge clk); #1;
               g++;
            end
         end
      join
      check("lw8_count", 64'(got8.size()), 64'd16);
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 2; k++) begin
            int idx;
            idx = 2 * c + k;
            check("lw8_beat", (idx < got8.size()) ? got8[idx] : 64'hx, exp_beat(8, 0, c, k));
         end
      end
      if (got8.size() == 16) begin
         for (int c = 0; c < 8; c++) begin
            check("lw8_mid_gap", 64'(got8_cyc[2 * c + 1] - got8_cyc[2 * c]), 64'd1);
            // a center that still needs a fresh pixel costs one extra input cycle
            if (c > 0)
               check("lw8_center_gap", 64'(got8_cyc[2 * c] - got8_cyc[2 * c - 2]),
                     (c + 2 <= 7) ? 64'd3 : 64'd2);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/cubic_tap_window.md
Name: cubic_tap_window

Overview:
- Upstream feeder for the cubic interpolation datapath in the 2x horizontal upscaler.
- Accepts one row of pixels at a time on a valid/ready stream and keeps a 4-sample sliding window, replicating samples at the row edges.
- For each source pixel it emits two window beats to the interpolator: first the original pixel position (`out_interp=0`), then the half-pixel midpoint (`out_interp=1`).
- Each beat presents `a0..a3` = p[i-1], p[i], p[i+1], p[i+2], with indices clamped to 0..line_width-1.

Parameters:
- `bit_depth`, 8, pixel sample width.
- `line_width`, 640, pixels per input row. Must be >= 4.

Ports:
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  input pixel valid.
- `in_ready`  output  1  block can accept an input pixel.
- `in_data`  input  bit_depth  input pixel.
- `out_valid`  output  1  window beat valid.
- `out_ready`  input  1  downstream accepts the beat.
- `a0`, `a1`, `a2`, `a3`  output  bit_depth each  window samples p[i-1], p[i], p[i+1], p[i+2], clamped.
- `out_interp`  output  1  0 = original-position beat, 1 = midpoint beat.
- `out_last`  output  1  final beat of the row.

Behaviour:
- Transfer rule: a transfer occurs when valid and ready are both high on a rising `clk` edge.
- Reset (asynchronous, effective immediately):
  - State goes to FILL; pixel counter and center counter go to 0.
  - `out_valid`, `out_interp`, `out_last` = 0; `a0..a3` = 0.
  - `in_ready` = 0 while `reset` is high, and 1 in the first cycle after release.
  - A reset mid-row discards the partial row; the next accepted pixel is p0 of a new row.
- States: FILL, EMIT0, EMIT1, WAIT_IN.
- FILL:
  - `in_ready` = 1; accepts p0, p1, p2 (pixel count 0..2).
  - On accepting p2, load the window with {p0, p0, p1, p2}, set center = 0, go to EMIT0.
  - `out_valid` rises the cycle after p2 is accepted.
- EMIT0:
  - `out_valid` = 1, `out_interp` = 0, `in_ready` = 0.
  - On transfer, go to EMIT1.
- EMIT1:
  - `out_valid` = 1, `out_interp` = 1, `in_ready` = 0.
  - `out_last` = 1 only when center == line_width-1.
  - On transfer:
    - If pixels received < line_width, go to WAIT_IN.
    - Else if center < line_width-1 (drain): shift the window left, replicating the old `a3` into `a3`, increment center, go to EMIT0.
    - Else (row complete): clear counters, go to FILL.
- WAIT_IN:
  - `in_ready` = 1, `out_valid` = 0.
  - On accepting a pixel: shift the window left with the new pixel into `a3`, increment center and pixel count, go to EMIT0.
- Output stability: while `out_valid` is high and `out_ready` is low, `a0..a3`, `out_interp` and `out_last` hold unchanged.
- Input side: `in_ready` never depends combinationally on `in_valid`. `in_data` is sampled only on a transfer.
- Beat count: exactly 2*line_width beats per row.
  - Centers 0..line_width-3 are emitted as input arrives.
  - Centers line_width-2 and line_width-1 are emitted in drain with `in_ready` = 0.
- Throughput: with `in_valid` and `out_ready` held high, steady state is one center per 3 cycles (EMIT0, EMIT1, WAIT_IN). Drain centers take 2 cycles each.
- Counters are $clog2(line_width+1) bits and wrap only through the explicit clear at row end.
- Back-to-back rows: FILL for row n+1 starts the cycle after row n's `out_last` transfer. Input is not accepted before then.
- Datapath: no arithmetic. Samples pass unmodified at `bit_depth` bits.

Test Plan:
- Basic row, `line_width`=4, input 10, 20, 30, 40, `out_ready`=1 -> 8 beats:
  - {10,10,20,30} `out_interp`=0, then =1
  - {10,20,30,40} ×2
  - {20,30,40,40} ×2
  - {30,40,40,40} ×2, with `out_last`=1 only on the 8th beat.
  - `in_ready`=0 throughout the last 4 beats.
- Latency and throughput: p2 accepted at cycle n -> `out_valid`=1 at n+1. With continuous stimulus, `line_width`=8 yields 16 beats with consecutive centers 3 cycles apart, drain centers 2 cycles apart.
- Backpressure: `out_ready`=0 for 5 cycles during the EMIT1 of center 1 -> `a0..a3` = {10,20,30,40} and `out_interp`=1 stay constant. No input is accepted. The sequence resumes unchanged.
- Input bubbles: `in_valid` toggling 1/0 each cycle -> identical beat sequence to the basic row, with `out_valid` low only in WAIT_IN.
- Two rows back to back, `line_width`=4, rows 1..4 then 200..203 -> second row's first beat is {200,200,201,202}. No sample from row 1 leaks into row 2.
- Reset mid-row after 2 pixels of row 1 -> all outputs 0 immediately. After release, rows 5, 6, 7, 8 produce first beat {5,5,6,7}.
